// File: rtl/slot_reels.sv
// Three-reel slot machine spinner feeding the HEX decoders and the slots win/lose FSM.
// Reels advance on a divided tick with LFSR-jittered steps. key_1, key_2 and key_3 stop
// reels 1, 2 and 3 in order, and a further key_3 press restarts the spin.
// Optional feature macro: SLOT_REELS_FORCE_SEVEN_EN adds force_seven, which makes every
// lock load 7.
module slot_reels #(
   parameter int unsigned TICK_DIV  = 2500000,
   parameter int unsigned REEL_MAX  = 9,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       resetn,
`ifdef SLOT_REELS_FORCE_SEVEN_EN
   input  logic       force_seven,
`endif
   input  logic       key_1,
   input  logic       key_2,
   input  logic       key_3,
   output logic [4:0] randomNum1,
   output logic [4:0] randomNum2,
   output logic [4:0] randomNum3,
   output logic [2:0] locked,
   output logic       done
);

   localparam int unsigned CNT_W = $clog2(TICK_DIV);
   // An all-zero seed would lock the LFSR up, so fall back to the default seed.
   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
   localparam logic [5:0] MAX6 = 6'(REEL_MAX);
   localparam logic [5:0] MOD6 = 6'(REEL_MAX + 1);

   typedef enum logic [1:0] {StSpin1, StSpin2, StSpin3, StDone} state_t;

   state_t           state_q;
   logic [2:0]       key_q;
   logic [2:0]       press;
   logic [CNT_W-1:0] cnt_q;
   logic             tick;
   logic [15:0]      lfsr_q;
   logic [15:0]      lfsr_d;
   logic [4:0]       reel1_q, reel2_q, reel3_q;
   logic [4:0]       adv1, adv2, adv3;
   logic [2:0]       locked_q;
   logic             done_q;
   logic             force_lock;

`ifdef SLOT_REELS_FORCE_SEVEN_EN
   assign force_lock = force_seven;
`else
   assign force_lock = 1'b0;
`endif

   // Advance by 1 or 2; the 6-bit sum keeps the wrap exact for REEL_MAX up to 30.
   function automatic logic [4:0] reel_adv(input logic [4:0] v, input logic jitter);
      logic [5:0] nxt;
      nxt = {1'b0, v} + 6'd1 + {5'd0, jitter};
      if (nxt > MAX6) begin
         nxt = nxt - MOD6;
      end
      return nxt[4:0];
   endfunction

   function automatic logic [4:0] lock_val(input logic [4:0] v, input logic frc);
      return frc ? 5'd7 : v;
   endfunction

   // Press detect, tick decode, LFSR next state and candidate reel values.
   always_comb begin
      press  = key_q & ~{key_3, key_2, key_1};
      tick   = (cnt_q == CNT_W'(TICK_DIV - 1));
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      adv1   = reel_adv(reel1_q, lfsr_q[0]);
      adv2   = reel_adv(reel2_q, lfsr_q[5]);
      adv3   = reel_adv(reel3_q, lfsr_q[10]);
   end

   // Stop-sequence FSM with registered reels, lock flags and done.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= StSpin1;
         key_q    <= 3'b111;
         cnt_q    <= '0;
         lfsr_q   <= SEED;
         reel1_q  <= 5'd0;
         reel2_q  <= 5'd0;
         reel3_q  <= 5'd0;
         locked_q <= 3'b000;
         done_q   <= 1'b0;
      end else begin
         key_q  <= {key_3, key_2, key_1};
         cnt_q  <= tick ? '0 : cnt_q + CNT_W'(1);
         lfsr_q <= lfsr_d;
         if (tick && !locked_q[0]) reel1_q <= adv1;
         if (tick && !locked_q[1]) reel2_q <= adv2;
         if (tick && !locked_q[2]) reel3_q <= adv3;
         // Lock assignments come last so a press on a tick cycle wins over the advance.
         unique case (state_q)
            StSpin1: begin
               if (press[0]) begin
                  reel1_q     <= lock_val(reel1_q, force_lock);
                  locked_q[0] <= 1'b1;
                  state_q     <= StSpin2;
               end
            end
            StSpin2: begin
               if (press[1]) begin
                  reel2_q     <= lock_val(reel2_q, force_lock);
                  locked_q[1] <= 1'b1;
                  state_q     <= StSpin3;
               end
            end
            StSpin3: begin
               if (press[2]) begin
                  reel3_q     <= lock_val(reel3_q, force_lock);
                  locked_q[2] <= 1'b1;
                  done_q      <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (press[2]) begin
                  locked_q <= 3'b000;
                  done_q   <= 1'b0;
                  state_q  <= StSpin1;
               end
            end
            default: state_q <= StSpin1;
         endcase
      end
   end

   assign randomNum1 = reel1_q;
   assign randomNum2 = reel2_q;
   assign randomNum3 = reel3_q;
   assign locked     = locked_q;
   assign done       = done_q;

endmodule

// File: tb/tb_slot_reels.sv
// Directed bench for slot_reels (TICK_DIV=4, REEL_MAX=9, seed 16'hACE1).
// Early reel values are hand-derived constants; later steps use a small reference model.
module tb_slot_reels;

   localparam int TickDiv = 4;
   localparam int ReelMax = 9;

   logic       clk;
   logic       resetn;
   logic       key_1, key_2, key_3;
   logic [4:0] randomNum1, randomNum2, randomNum3;
   logic [2:0] locked;
   logic       done;
   logic       m_fs;
`ifdef SLOT_REELS_FORCE_SEVEN_EN
   logic       force_seven;
   assign m_fs = force_seven;
`else
   assign m_fs = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   slot_reels #(
      .TICK_DIV (TickDiv),
      .REEL_MAX (ReelMax),
      .LFSR_SEED(16'hACE1)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
`ifdef SLOT_REELS_FORCE_SEVEN_EN
      .force_seven(force_seven),
`endif
      .key_1     (key_1),
      .key_2     (key_2),
      .key_3     (key_3),
      .randomNum1(randomNum1),
      .randomNum2(randomNum2),
      .randomNum3(randomNum3),
      .locked    (locked),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: state index 0..2 = spinning stage, 3 = all stopped.
   logic [15:0] m_lfsr, m_lfsr_d;
   int          m_cnt, m_cnt_d;
   int          m_r[3];
   int          m_r_d[3];
   int          m_step[3];
   logic [2:0]  m_locked, m_locked_d;
   int          m_st, m_st_d;
   logic [2:0]  m_kq;
   logic [2:0]  m_press;
   logic        m_tick;

   always_comb begin
      m_press    = m_kq & ~{key_3, key_2, key_1};
      m_tick     = (m_cnt == TickDiv - 1);
      m_step[0]  = 1 + int'(m_lfsr[0]);
      m_step[1]  = 1 + int'(m_lfsr[5]);
      m_step[2]  = 1 + int'(m_lfsr[10]);
      m_locked_d = m_locked;
      m_st_d     = m_st;
      for (int i = 0; i < 3; i++) begin
         m_r_d[i] = m_r[i];
         if (m_tick && !m_locked[i]) m_r_d[i] = (m_r[i] + m_step[i]) % (ReelMax + 1);
      end
      case (m_st)
         0, 1, 2: begin
            if (m_press[m_st]) begin
               m_locked_d[m_st] = 1'b1;
               m_r_d[m_st]      = m_fs ? 7 : m_r[m_st];
               m_st_d           = m_st + 1;
            end
         end
         default: begin
            if (m_press[2]) begin
               m_locked_d = 3'b000;
               m_st_d     = 0;
            end
         end
      endcase
      m_cnt_d  = (m_cnt + 1) % TickDiv;
      m_lfsr_d = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
   end

   // Model state update, on the same edge as the DUT.
   always @(posedge clk) begin
      if (!resetn) begin
         m_lfsr   <= 16'hACE1;
         m_cnt    <= 0;
         m_r      <= '{0, 0, 0};
         m_locked <= 3'b000;
         m_st     <= 0;
         m_kq     <= 3'b111;
      end else begin
         m_lfsr   <= m_lfsr_d;
         m_cnt    <= m_cnt_d;
         m_r      <= m_r_d;
         m_locked <= m_locked_d;
         m_st     <= m_st_d;
         m_kq     <= {key_3, key_2, key_1};
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".r1"}, 32'(randomNum1), 32'(m_r[0]));
      check({tag, ".r2"}, 32'(randomNum2), 32'(m_r[1]));
      check({tag, ".r3"}, 32'(randomNum3), 32'(m_r[2]));
      check({tag, ".locked"}, 32'(locked), 32'(m_locked));
      check({tag, ".done"}, 32'(done), 32'(m_st == 3));
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".r1"}, 32'(randomNum1), 32'd0);
      check({tag, ".r2"}, 32'(randomNum2), 32'd0);
      check({tag, ".r3"}, 32'(randomNum3), 32'd0);
      check({tag, ".locked"}, 32'(locked), 32'd0);
      check({tag, ".done"}, 32'(done), 32'd0);
   endtask

   // Drive the selected keys low across exactly one rising edge; called and returns at negedge.
   task automatic press(input logic [2:0] keys);
      {key_3, key_2, key_1} = ~keys;
      @(negedge clk);
      {key_3, key_2, key_1} = 3'b111;
      @(negedge clk);
   endtask

   initial begin
      int bad;
      int maxv;
      resetn = 1'b0;
      {key_3, key_2, key_1} = 3'b111;
`ifdef SLOT_REELS_FORCE_SEVEN_EN
      force_seven = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check_zero("reset");

      // First tick lands on edge 4 after release; LFSR 16'h559C gives steps 1,1,2.
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      check("pre_tick.r1", 32'(randomNum1), 32'd0);
      @(negedge clk);
      check("tick1.r1", 32'(randomNum1), 32'd1);
      check("tick1.r2", 32'(randomNum2), 32'd1);
      check("tick1.r3", 32'(randomNum3), 32'd2);
      repeat (3) @(negedge clk);
      check("hold.r1", 32'(randomNum1), 32'd1);
      @(negedge clk);
      // Second tick uses LFSR 16'h4559: steps 2,1,2.
      check("tick2.r1", 32'(randomNum1), 32'd3);
      check("tick2.r2", 32'(randomNum2), 32'd2);
      check("tick2.r3", 32'(randomNum3), 32'd4);
      check_all("tick2");

      // Out-of-order keys in SPIN1 are ignored.
      press(3'b100);
      press(3'b010);
      check("ooo.locked", 32'(locked), 32'd0);
      check_all("ooo");

      // Holding key_1 gives one press; reel 1 frozen, others keep spinning.
      key_1 = 1'b0;
      repeat (10) @(negedge clk);
      check("hold_k1.locked", 32'(locked), 32'd1);
      check_all("hold_k1");
      key_1 = 1'b1;
      @(negedge clk);

      // Simultaneous unexpected keys, then expected key alongside an unexpected one.
      press(3'b101);
      check("sim_bad.locked", 32'(locked), 32'd1);
      press(3'b110);
      check("sim_k2.locked", 32'(locked), 32'd3);
      check("sim_k2.done", 32'(done), 32'd0);
      check_all("sim_k2");
      press(3'b100);
      check("stop_all.locked", 32'(locked), 32'd7);
      check("stop_all.done", 32'(done), 32'd1);
      check_all("stop_all");
      repeat (100) @(negedge clk);
      check_all("done_hold");

      // Restart from DONE: locks clear, values retained until next tick.
      press(3'b100);
      check("restart.locked", 32'(locked), 32'd0);
      check("restart.done", 32'(done), 32'd0);
      check_all("restart");

      // Long free spin: DUT tracks the model and never exceeds REEL_MAX.
      bad  = 0;
      maxv = 0;
      for (int i = 0; i < 40000; i++) begin
         @(negedge clk);
         if (int'(randomNum1) != m_r[0] || int'(randomNum2) != m_r[1] ||
             int'(randomNum3) != m_r[2]) bad++;
         if (int'(randomNum1) > maxv) maxv = int'(randomNum1);
         if (int'(randomNum2) > maxv) maxv = int'(randomNum2);
         if (int'(randomNum3) > maxv) maxv = int'(randomNum3);
      end
      check("soak.mismatch_cycles", 32'(bad), 32'd0);
      check("soak.max_le_reel_max", 32'(maxv <= ReelMax), 32'd1);

      // Reset in the middle of SPIN2.
      press(3'b001);
      check("spin2.locked", 32'(locked), 32'd1);
      resetn = 1'b0;
      @(negedge clk);
      check_zero("mid_reset");
      resetn = 1'b1;
      press(3'b010);
      check("post_reset_k2.locked", 32'(locked), 32'd0);
      press(3'b001);
      check("post_reset_k1.locked", 32'(locked), 32'd1);
      check_all("post_reset");

`ifdef SLOT_REELS_FORCE_SEVEN_EN
      // Forced win: remaining locks load 7 regardless of reel position.
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      force_seven = 1'b1;
      repeat (6) @(negedge clk);
      press(3'b001);
      repeat (3) @(negedge clk);
      press(3'b010);
      repeat (5) @(negedge clk);
      press(3'b100);
      repeat (8) @(negedge clk);
      check("seven.r1", 32'(randomNum1), 32'd7);
      check("seven.r2", 32'(randomNum2), 32'd7);
      check("seven.r3", 32'(randomNum3), 32'd7);
      check("seven.done", 32'(done), 32'd1);
      force_seven = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/slot_reels.md
Name: slot_reels

Overview:
- Upstream stage of the slots win/lose FSM. Produces the three 5-bit reel values that the FSM compares against 7.
- Three reels spin on a divided tick, with a 16-bit LFSR jittering the step size. KEY3, KEY2 and KEY1 stop reels 1, 2 and 3 in order.
- Once all reels have stopped, a further KEY1 press restarts the spin.
- Outputs drive the HEX decoders and the slots FSM directly.

Parameters:
- TICK_DIV, 2500000: clk cycles per reel-advance tick (20 Hz at 50 MHz). Legal range is 2 or more.
- REEL_MAX, 9: highest reel value; reels take values 0..REEL_MAX. Legal range is 7 to 30, so that 7 is always reachable.
- LFSR_SEED, 16'hACE1: LFSR reset value. A seed of 0 is replaced by 16'hACE1.

Ports:
- clk, input, 1: system clock.
- resetn, input, 1: synchronous active-low reset.
- key_1, input, 1: KEY3, active-low. Stops reel 1.
- key_2, input, 1: KEY2, active-low. Stops reel 2.
- key_3, input, 1: KEY1, active-low. Stops reel 3; also restarts after all reels have stopped.
- randomNum1, output, 5: reel 1 value.
- randomNum2, output, 5: reel 2 value.
- randomNum3, output, 5: reel 3 value.
- locked, output, 3: bit i-1 is high when reel i has stopped.
- done, output, 1: high while all three reels are stopped.

Behaviour:
- Reset (resetn low at a clk edge):
  - randomNum1/2/3 = 0; locked = 3'b000; done = 0.
  - State = SPIN1; tick counter = 0; LFSR = LFSR_SEED.
  - Key history registers = 1 (released).
- Key press detection:
  - Each key is registered once per clk.
  - A press is a 1-cycle pulse, asserted when the previous sample is 1 and the current raw input is 0.
  - Holding a key produces exactly one press. No debounce in this block.
- Tick generation:
  - The counter counts 0..TICK_DIV-1 and wraps to 0.
  - tick is high during the cycle in which counter == TICK_DIV-1.
- LFSR:
  - Fibonacci form, taps 16,14,13,11; shifts every clk, including when idle.
- Reel advance, for each reel not locked, on tick:
  - step = 1 + lfsr[k], with k = 0, 5, 10 for reels 1, 2, 3.
  - next = v + step. If next > REEL_MAX, next = next - (REEL_MAX+1). Computed in 6 bits, so the wrap is exact.
  - Values never exceed REEL_MAX.
- FSM states and transitions:
  - SPIN1: all reels spinning. A key_1 press locks reel 1 and moves to SPIN2.
  - SPIN2: reels 2 and 3 spinning. A key_2 press locks reel 2 and moves to SPIN3.
  - SPIN3: reel 3 spinning. A key_3 press locks reel 3 and moves to DONE.
  - DONE: done = 1, all values held. A key_3 press clears locked and done and moves to SPIN1; values are retained and spinning resumes on the next tick.
- Lock timing:
  - The locked value equals the reel value registered on the press cycle.
  - If the press coincides with tick, lock wins and that reel does not advance.
  - locked and the state update on the same edge.
- Out-of-order and simultaneous keys:
  - Presses of a key not expected in the current state are ignored.
  - With simultaneous presses, only the expected key acts; at most one transition per cycle.
  - The key_3 press that enters DONE does not also restart; a fresh press is required.
- Reset mid-spin or in DONE returns everything to the reset values on that edge, regardless of keys.
- Outputs are registered with no combinational path from keys.

Optional Feature:
- Macro: SLOT_REELS_FORCE_SEVEN_EN.
- When defined:
  - Adds port force_seven (input, 1).
  - While force_seven = 1, a lock event loads 5'd7 into the reel being locked instead of its current value. This provides a deterministic win for demos and the slots FSM bench.
- When undefined:
  - The port is absent and locks capture the current value.

Test Plan:
- TICK_DIV=4, resetn low 2 cycles then high, no keys -> all values 0, locked=000, done=0; reel 1 first changes on cycle 4 after release to 1 or 2.
- Hold key_1 low 10 cycles during SPIN1 -> locked=001 after a single press; randomNum1 frozen at its press-cycle value while reels 2 and 3 keep advancing.
- Press key_3 then key_2 in SPIN1 -> no state change, locked=000; then key_1, key_2, key_3 in order -> locked=111, done=1, values stable for 100 cycles.
- REEL_MAX=9, force the LFSR so step=2 at v=9 -> next value 1; over 10000 ticks randomNum never exceeds 9.
- In DONE, press key_3 -> locked=000, done=0, values unchanged until the next tick; assert resetn mid-SPIN2 -> all outputs 0 and state SPIN1 on that edge.
- With SLOT_REELS_FORCE_SEVEN_EN and force_seven=1, run the stop sequence -> randomNum1/2/3 = 7/7/7, done=1.
